// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: per-stage hold/flush
// decisions, PC redirect for taken jumps and interrupts, and a stall counter.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module pipe_hazard_ctrl #(
    parameter int                    WORD_WIDTH     = `WORD_WIDTH,
    parameter int                    REG_ADDR_WIDTH = 5,
    parameter logic [WORD_WIDTH-1:0] NOP_INST       = 'h0000_0013,
    parameter int                    FLUSH_CYCLES   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      jump_flag_i,
    input  logic [WORD_WIDTH-1:0]     jump_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
    input  logic                      ex_load_i,
    input  logic                      mdu_start_i,
    input  logic                      mdu_done_i,
    input  logic                      int_req_i,
    input  logic [WORD_WIDTH-1:0]     int_addr_i,
    output logic                      int_ack_o,
    output logic                      redirect_o,
    output logic [WORD_WIDTH-1:0]     redirect_addr_o,
    output logic                      hold_pc_o,
    output logic                      hold_if_id_o,
    output logic                      hold_id_ex_o,
    output logic                      flush_if_id_o,
    output logic                      flush_id_ex_o,
    output logic                      flush_ex_mem_o,
    output logic [WORD_WIDTH-1:0]     nop_inst_o,
    output logic [31:0]               stall_cnt_o
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MDU_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_e;

    // FLUSH covers the extra fetch-latency cycles beyond the redirect cycle itself.
    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);
    localparam bit         GO_FLUSH  = (FLUSH_CYCLES > 1);

    state_e      state_q, state_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        lu;

    assign lu = ex_load_i && (ex_rd_i != '0) &&
                ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                 (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

    always_comb begin
        state_d         = state_q;
        fcnt_d          = fcnt_q;
        int_ack_o       = 1'b0;
        redirect_o      = 1'b0;
        redirect_addr_o = '0;
        hold_pc_o       = 1'b0;
        hold_if_id_o    = 1'b0;
        hold_id_ex_o    = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        flush_ex_mem_o  = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (jump_flag_i) begin
                    redirect_o      = 1'b1;
                    redirect_addr_o = jump_addr_i;
                    flush_if_id_o   = 1'b1;
                    flush_id_ex_o   = 1'b1;
                    if (GO_FLUSH) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FCNT_INIT;
                    end
                end else if (mdu_start_i) begin
                    hold_pc_o      = 1'b1;
                    hold_if_id_o   = 1'b1;
                    hold_id_ex_o   = 1'b1;
                    flush_ex_mem_o = 1'b1;
                    state_d        = S_MDU_WAIT;
                end else if (lu) begin
                    // One bubble: the load moves to MEM and the hazard resolves itself.
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (int_req_i) begin
                    int_ack_o       = 1'b1;
                    redirect_o      = 1'b1;
                    redirect_addr_o = int_addr_i;
                    flush_if_id_o   = 1'b1;
                    flush_id_ex_o   = 1'b1;
                    if (GO_FLUSH) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FCNT_INIT;
                    end
                end
            end
            S_MDU_WAIT: begin
                if (mdu_done_i) begin
                    state_d = S_RUN;
                end else begin
                    hold_pc_o      = 1'b1;
                    hold_if_id_o   = 1'b1;
                    hold_id_ex_o   = 1'b1;
                    flush_ex_mem_o = 1'b1;
                end
            end
            S_FLUSH: begin
                // EX only holds a bubble here; interrupts wait for RUN (level request).
                flush_if_id_o = 1'b1;
                if (fcnt_q <= 2'd1) begin
                    fcnt_d  = 2'd0;
                    state_d = S_RUN;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                end
            end
            default: begin
                state_d = S_RUN;
                fcnt_d  = 2'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hold_pc_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            fcnt_q      <= 2'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign nop_inst_o  = NOP_INST;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (FLUSH_CYCLES=1 and 3) share inputs.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_flag, id_rs1_used, id_rs2_used, ex_load, mdu_start, mdu_done, int_req;
    logic [31:0] jump_addr, int_addr;
    logic [4:0]  id_rs1, id_rs2, ex_rd;

    logic        ack1, rd1, hpc1, hif1, hidex1, fif1, fidex1, fexm1;
    logic        ack3, rd3, hpc3, hif3, hidex3, fif3, fidex3, fexm3;
    logic [31:0] addr1, addr3, nop1, nop3, scnt1, scnt3;
    logic [7:0]  ctl1, ctl3;

    int total = 0;
    int bad   = 0;

    // {int_ack, redirect, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, flush_ex_mem}
    assign ctl1 = {ack1, rd1, hpc1, hif1, hidex1, fif1, fidex1, fexm1};
    assign ctl3 = {ack3, rd3, hpc3, hif3, hidex3, fif3, fidex3, fexm3};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_used_i(id_rs1_used),
        .id_rs2_used_i(id_rs2_used), .ex_rd_i(ex_rd), .ex_load_i(ex_load),
        .mdu_start_i(mdu_start), .mdu_done_i(mdu_done), .int_req_i(int_req),
        .int_addr_i(int_addr), .int_ack_o(ack1), .redirect_o(rd1), .redirect_addr_o(addr1),
        .hold_pc_o(hpc1), .hold_if_id_o(hif1), .hold_id_ex_o(hidex1),
        .flush_if_id_o(fif1), .flush_id_ex_o(fidex1), .flush_ex_mem_o(fexm1),
        .nop_inst_o(nop1), .stall_cnt_o(scnt1)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_used_i(id_rs1_used),
        .id_rs2_used_i(id_rs2_used), .ex_rd_i(ex_rd), .ex_load_i(ex_load),
        .mdu_start_i(mdu_start), .mdu_done_i(mdu_done), .int_req_i(int_req),
        .int_addr_i(int_addr), .int_ack_o(ack3), .redirect_o(rd3), .redirect_addr_o(addr3),
        .hold_pc_o(hpc3), .hold_if_id_o(hif3), .hold_id_ex_o(hidex3),
        .flush_if_id_o(fif3), .flush_id_ex_o(fidex3), .flush_ex_mem_o(fexm3),
        .nop_inst_o(nop3), .stall_cnt_o(scnt3)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        jump_flag = 0; jump_addr = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0;
        id_rs2_used = 0; ex_rd = 0; ex_load = 0; mdu_start = 0; mdu_done = 0;
        int_req = 0; int_addr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        total++; if (ctl1 !== 8'h00) begin bad++; $display("FAIL reset_ctl1 got=%b exp=%b", ctl1, 8'h00); end
        total++; if (ctl3 !== 8'h00) begin bad++; $display("FAIL reset_ctl3 got=%b exp=%b", ctl3, 8'h00); end
        total++; if (addr1 !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr1); end
        total++; if (scnt1 !== 32'h0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", scnt1); end
        total++; if (nop1 !== 32'h0000_0013) begin bad++; $display("FAIL reset_nop got=%h exp=00000013", nop1); end
        tick(); tick();
        rst_n = 1;
        #4;
        total++; if (ctl1 !== 8'h00) begin bad++; $display("FAIL post_reset_ctl1 got=%b exp=0", ctl1); end
        tick();
    endtask

    task automatic test_jump();
        jump_flag = 1; jump_addr = 32'h0000_0100;
        #4;
        total++; if (ctl1 !== 8'b0100_0110) begin bad++; $display("FAIL jump_ctl1 got=%b exp=%b", ctl1, 8'b0100_0110); end
        total++; if (addr1 !== 32'h100) begin bad++; $display("FAIL jump_addr1 got=%h exp=00000100", addr1); end
        total++; if (ctl3 !== 8'b0100_0110) begin bad++; $display("FAIL jump_ctl3 got=%b exp=%b", ctl3, 8'b0100_0110); end
        tick();
        jump_flag = 0; jump_addr = 32'h0000_0200;
        #4;
        total++; if (ctl1 !== 8'h00) begin bad++; $display("FAIL jump_after_ctl1 got=%b exp=0", ctl1); end
        total++; if (addr1 !== 32'h0) begin bad++; $display("FAIL jump_after_addr1 got=%h exp=0", addr1); end
        total++; if (ctl3 !== 8'b0000_0100) begin bad++; $display("FAIL jump_flush1_ctl3 got=%b exp=%b", ctl3, 8'b0000_0100); end
        tick();
        #4;
        total++; if (ctl3 !== 8'b0000_0100) begin bad++; $display("FAIL jump_flush2_ctl3 got=%b exp=%b", ctl3, 8'b0000_0100); end
        tick();
        #4;
        total++; if (ctl3 !== 8'h00) begin bad++; $display("FAIL jump_done_ctl3 got=%b exp=0", ctl3); end
        jump_addr = 0;
    endtask

    task automatic test_load_use();
        ex_load = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
        #4;
        total++; if (ctl1 !== 8'b0011_0010) begin bad++; $display("FAIL lu_ctl1 got=%b exp=%b", ctl1, 8'b0011_0010); end
        total++; if (scnt1 !== 32'd0) begin bad++; $display("FAIL lu_stall_before got=%0d exp=0", scnt1); end
        tick();
        ex_load = 0;
        #4;
        total++; if (ctl1 !== 8'h00) begin bad++; $display("FAIL lu_after_ctl1 got=%b exp=0", ctl1); end
        total++; if (scnt1 !== 32'd1) begin bad++; $display("FAIL lu_stall_after got=%0d exp=1", scnt1); end
        ex_load = 1; ex_rd = 0; id_rs2 = 0;
        #2;
        total++; if (ctl1 !== 8'h00) begin bad++; $display("FAIL lu_rd0_ctl1 got=%b exp=0", ctl1); end
        ex_rd = 5; id_rs2 = 5; id_rs2_used = 0;
        #2;
        total++; if (ctl1 !== 8'h00) begin bad++; $display("FAIL lu_unused_ctl1 got=%b exp=0", ctl1); end
        tick();
        id_rs1 = 5; id_rs1_used = 1;
        #4;
        total++; if (ctl1 !== 8'b0011_0010) begin bad++; $display("FAIL lu_rs1_ctl1 got=%b exp=%b", ctl1, 8'b0011_0010); end
        tick();
        ex_load = 0; ex_rd = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0;
        #4;
        total++; if (scnt1 !== 32'd2) begin bad++; $display("FAIL lu_stall_two got=%0d exp=2", scnt1); end
        tick();
    endtask

    task automatic test_mdu();
        mdu_start = 1;
        #4;
        total++; if (ctl1 !== 8'b0011_1001) begin bad++; $display("FAIL mdu_start_ctl1 got=%b exp=%b", ctl1, 8'b0011_1001); end
        tick();
        mdu_start = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin jump_flag = 1; jump_addr = 32'h0000_0300; int_req = 1; int_addr = 32'h0000_0040; end
            #4;
            total++; if (ctl1 !== 8'b0011_1001) begin bad++; $display("FAIL mdu_wait%0d_ctl1 got=%b exp=%b", c, ctl1, 8'b0011_1001); end
            total++; if (addr1 !== 32'h0) begin bad++; $display("FAIL mdu_wait%0d_addr got=%h exp=0", c, addr1); end
            tick();
            jump_flag = 0; int_req = 0;
        end
        mdu_done = 1;
        #4;
        total++; if (ctl1 !== 8'h00) begin bad++; $display("FAIL mdu_done_ctl1 got=%b exp=0", ctl1); end
        tick();
        mdu_done = 0; jump_addr = 0; int_addr = 0;
        #4;
        total++; if (scnt1 !== 32'd6) begin bad++; $display("FAIL mdu_stall got=%0d exp=6", scnt1); end
        total++; if (ctl1 !== 8'h00) begin bad++; $display("FAIL mdu_run_ctl1 got=%b exp=0", ctl1); end
        tick();
    endtask

    task automatic test_interrupt();
        int_req = 1; int_addr = 32'h8000_0004;
        #4;
        total++; if (ctl3 !== 8'b1100_0110) begin bad++; $display("FAIL int_take_ctl3 got=%b exp=%b", ctl3, 8'b1100_0110); end
        total++; if (addr3 !== 32'h8000_0004) begin bad++; $display("FAIL int_addr3 got=%h exp=80000004", addr3); end
        tick();
        for (int c = 1; c <= 2; c++) begin
            #4;
            total++; if (ctl3 !== 8'b0000_0100) begin bad++; $display("FAIL int_flush%0d_ctl3 got=%b exp=%b", c, ctl3, 8'b0000_0100); end
            tick();
        end
        #4;
        total++; if (ctl3 !== 8'b1100_0110) begin bad++; $display("FAIL int_retake_ctl3 got=%b exp=%b", ctl3, 8'b1100_0110); end
        tick();
        int_req = 0; int_addr = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_priority();
        jump_flag = 1; jump_addr = 32'h0000_0200;
        ex_load = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 1;
        int_req = 1; int_addr = 32'h8000_0004;
        #4;
        total++; if (ctl1 !== 8'b0100_0110) begin bad++; $display("FAIL prio_ctl1 got=%b exp=%b", ctl1, 8'b0100_0110); end
        total++; if (addr1 !== 32'h200) begin bad++; $display("FAIL prio_addr1 got=%h exp=00000200", addr1); end
        tick();
        jump_flag = 0; jump_addr = 0; ex_load = 0; ex_rd = 0; id_rs1 = 0; id_rs1_used = 0;
        #4;
        total++; if (ctl1 !== 8'b1100_0110) begin bad++; $display("FAIL prio_int1_ctl1 got=%b exp=%b", ctl1, 8'b1100_0110); end
        total++; if (addr1 !== 32'h8000_0004) begin bad++; $display("FAIL prio_int1_addr got=%h exp=80000004", addr1); end
        total++; if (ctl3 !== 8'b0000_0100) begin bad++; $display("FAIL prio_flush_ctl3 got=%b exp=%b", ctl3, 8'b0000_0100); end
        tick(); tick();
        #4;
        total++; if (ctl3 !== 8'b1100_0110) begin bad++; $display("FAIL prio_int3_ctl3 got=%b exp=%b", ctl3, 8'b1100_0110); end
        tick();
        int_req = 0; int_addr = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        mdu_start = 1;
        tick();
        mdu_start = 0;
        #2;
        total++; if (ctl1 !== 8'b0011_1001) begin bad++; $display("FAIL rmid_wait_ctl1 got=%b exp=%b", ctl1, 8'b0011_1001); end
        rst_n = 0;
        #1;
        total++; if (ctl1 !== 8'h00) begin bad++; $display("FAIL rmid_ctl1 got=%b exp=0", ctl1); end
        total++; if (scnt1 !== 32'd0) begin bad++; $display("FAIL rmid_stall got=%0d exp=0", scnt1); end
        tick();
        rst_n = 1;
        mdu_done = 1;
        #4;
        total++; if (ctl1 !== 8'h00) begin bad++; $display("FAIL rmid_done_ctl1 got=%b exp=0", ctl1); end
        tick();
        ex_load = 1; ex_rd = 3; id_rs2 = 3; id_rs2_used = 1;
        #4;
        total++; if (ctl1 !== 8'b0011_0010) begin bad++; $display("FAIL rmid_run_lu got=%b exp=%b", ctl1, 8'b0011_0010); end
        tick();
        idle_inputs();
        #4;
        total++; if (scnt1 !== 32'd1) begin bad++; $display("FAIL rmid_stall_after got=%0d exp=1", scnt1); end
    endtask

    initial begin
        test_reset();
        test_jump();
        tick();
        test_load_use();
        test_mdu();
        test_interrupt();
        test_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the mxrvcpu 5-stage pipeline. It decides each cycle, per stage register, whether to advance, hold or flush, and drives the PC redirect for taken jumps/branches and interrupts. Its flush outputs drive the flush input of the `s_bits_dff` stage registers, and `nop_inst_o` drives their flush-load value input. Hold outputs select the stage's own current output as its next D input.

## Interface
- `WORD_WIDTH`, default `` `WORD_WIDTH `` (32): PC, address and instruction width.
- `REG_ADDR_WIDTH`, default 5: register-index width.
- `NOP_INST`, default 32'h0000_0013: value loaded into flushed IF/ID instruction registers (`addi x0,x0,0`).
- `FLUSH_CYCLES`, default 1, legal 1–3: cycles `flush_if_id_o` stays asserted after a redirect, covering fetch latency.

Ports:
- `clk` in 1: the design's single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `jump_flag_i` in 1: EX has resolved a taken branch/jump (1-cycle pulse).
- `jump_addr_i` in WORD_WIDTH: jump target.
- `id_rs1_i`, `id_rs2_i` in REG_ADDR_WIDTH: source registers of the instruction in ID.
- `id_rs1_used_i`, `id_rs2_used_i` in 1: ID actually reads rs1/rs2.
- `ex_rd_i` in REG_ADDR_WIDTH: destination register of the instruction in EX.
- `ex_load_i` in 1: the instruction in EX is a load.
- `mdu_start_i` in 1: EX issues a multi-cycle mul/div (pulse).
- `mdu_done_i` in 1: MDU result is valid this cycle.
- `int_req_i` in 1: level interrupt request.
- `int_addr_i` in WORD_WIDTH: trap vector.
- `int_ack_o` out 1: interrupt taken (1-cycle pulse).
- `redirect_o` out 1: the PC loads `redirect_addr_o` at the next edge.
- `redirect_addr_o` out WORD_WIDTH: redirect target.
- `hold_pc_o`, `hold_if_id_o`, `hold_id_ex_o` out 1: the stage keeps its value.
- `flush_if_id_o`, `flush_id_ex_o`, `flush_ex_mem_o` out 1: the stage loads its flush value.
- `nop_inst_o` out WORD_WIDTH: constant `NOP_INST`.
- `stall_cnt_o` out 32: number of cycles in which `hold_pc_o` was asserted; saturates at 32'hFFFF_FFFF.

## Operation
- The FSM has three states: RUN, MDU_WAIT and FLUSH. A 2-bit counter `fcnt` is used in FLUSH.
- Load-use hazard (`lu`) is true when `ex_load_i` is high, `ex_rd_i` is non-zero, and `ex_rd_i` matches a used ID source register (rs1 with `id_rs1_used_i`, or rs2 with `id_rs2_used_i`).
- In RUN, exactly one action is taken per cycle, in this priority order:
  1. `jump_flag_i`: assert `redirect_o`, `redirect_addr_o`=`jump_addr_i`, `flush_if_id_o` and `flush_id_ex_o`. If `FLUSH_CYCLES`>1, go to FLUSH with `fcnt`=`FLUSH_CYCLES`-1; otherwise stay in RUN.
  2. `mdu_start_i`: assert `hold_pc_o`, `hold_if_id_o`, `hold_id_ex_o` and `flush_ex_mem_o`, then go to MDU_WAIT. `jump_flag_i` together with `mdu_start_i` is illegal; jump wins and `mdu_start_i` is ignored.
  3. `lu`: assert `hold_pc_o`, `hold_if_id_o` and `flush_id_ex_o` for that cycle only. Stay in RUN; the hazard clears once the load reaches MEM.
  4. `int_req_i`: assert `redirect_o`, `redirect_addr_o`=`int_addr_i`, `int_ack_o`, `flush_if_id_o` and `flush_id_ex_o`. Enter FLUSH exactly as a jump does.
  5. Otherwise all control outputs are low.
- MDU_WAIT:
  - Holds and `flush_ex_mem_o` stay asserted while `mdu_done_i`=0.
  - In the cycle `mdu_done_i`=1, all holds and flushes are low and the state returns to RUN.
  - `jump_flag_i`, `lu` and `int_req_i` are ignored.
- FLUSH:
  - Assert `flush_if_id_o` only and decrement `fcnt`. Return to RUN in the cycle `fcnt`=1.
  - `int_req_i` is deferred, not dropped, because it is level-sensitive. `jump_flag_i` is ignored, since EX holds a bubble.
- `mdu_done_i` outside MDU_WAIT is ignored.
- Whenever `redirect_o` is low, `redirect_addr_o` is driven to 0.

## Timing
- All outputs are combinational from state, `fcnt` and inputs. State, `fcnt` and `stall_cnt_o` are registered.
- Reset (asynchronous, mid-operation included): state RUN, `fcnt`=0, `stall_cnt_o`=0. All 1-bit outputs and `redirect_addr_o` are 0 during and after reset until stimulus arrives. `nop_inst_o`=`NOP_INST` always.
- Jump/interrupt penalty: 2 + (`FLUSH_CYCLES`-1) bubble cycles. The redirect occurs at the edge ending the request cycle.
- Load-use penalty: exactly 1 bubble.
- MDU stall: from the `mdu_start_i` cycle through the cycle before `mdu_done_i`. `stall_cnt_o` increments at each edge where `hold_pc_o`=1.

## Test plan
- **Jump:** `FLUSH_CYCLES`=1, `jump_flag_i`=1, `jump_addr_i`=32'h0000_0100 for 1 cycle -> in that cycle `redirect_o`=1, `redirect_addr_o`=32'h100, `flush_if_id_o`=`flush_id_ex_o`=1. Next cycle all outputs are 0 and the state is RUN.
- **Load-use:** `ex_load_i`=1, `ex_rd_i`=5, `id_rs2_i`=5, `id_rs2_used_i`=1 -> one cycle of `hold_pc_o`=`hold_if_id_o`=`flush_id_ex_o`=1, `stall_cnt_o` 0->1. With `ex_rd_i`=0, or with `id_rs2_used_i`=0, nothing is asserted.
- **MDU stall:** `mdu_start_i` pulse, then `mdu_done_i` high on the 4th following cycle -> holds and `flush_ex_mem_o` high for 4 cycles, low in the done cycle, `stall_cnt_o`=4. A `jump_flag_i` and an `int_req_i` pulsed mid-wait produce no redirect and no ack.
- **Interrupt:** `FLUSH_CYCLES`=3, `int_req_i` held with `int_addr_i`=32'h8000_0004 -> `int_ack_o` pulses exactly once and `redirect_addr_o`=32'h8000_0004. `flush_if_id_o` stays high for 3 cycles in total; the interrupt is not re-taken during FLUSH. If `int_req_i` is still high when the FSM returns to RUN, it is taken again.
- **Priority:** `jump_flag_i`, `lu` and `int_req_i` asserted in the same RUN cycle -> the jump target is used, `int_ack_o`=0 and there is no hold. The interrupt is taken in the first RUN cycle afterwards.
- **Reset:** `rst_n` dropped asynchronously in MDU_WAIT, mid-cycle -> all outputs 0 immediately and `stall_cnt_o`=0. After release the FSM is in RUN and `mdu_done_i` is ignored.
